// File: rtl/trng_burst_sequencer_if.sv
// Capture-RAM write/read port plus UART transmit handshake of the TRNG burst sequencer.
// Latency: none, wires only; backpressure: the UART holds off the sequencer with tx_busy.
interface trng_burst_sequencer_if #(
    parameter int AW = 1
);
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [7:0]    tx_data;
    logic          tx_wr_en;
    logic          tx_busy;

    modport master (
        output mem_we, mem_waddr, mem_wdata, mem_raddr, tx_data, tx_wr_en,
        input  mem_rdata, tx_busy
    );

    modport slave (
        input  mem_we, mem_waddr, mem_wdata, mem_raddr, tx_data, tx_wr_en,
        output mem_rdata, tx_busy
    );
endinterface

// File: rtl/trng_burst_sequencer.sv
// Captures NUM_BYTES of sampled oscillator bits into RAM, then streams them to the UART.
// Latency: write 1 cycle after the 8th sample, send 1 cycle after XMIT; backpressure: waits on tx_busy, times out after ACK_TIMEOUT.
module trng_burst_sequencer #(
    parameter int NUM_BYTES   = 125000,
    parameter int SAMPLE_DIV  = 32,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       rand_bit,
    output logic       osc_en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] state,
    trng_burst_sequencer_if.master bus
);
    localparam int AW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int SDW = $clog2(SAMPLE_DIV);
    localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_XMIT     = 3'd2,
        S_TX_ACK   = 3'd3,
        S_TX_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t         cur_state, nxt_state;
    logic           start_q;
    logic [SDW-1:0] samp_cnt;
    logic [2:0]     bit_cnt;
    logic [6:0]     shreg;
    logic [AW-1:0]  wr_idx, rd_idx;
    logic [TW-1:0]  ack_cnt;
    logic           mem_we_q;
    logic [7:0]     mem_wdata_q, tx_data_q;
    logic           tx_wr_en_q, error_q;

    logic accept, tick, last_wr, last_rd, ack_expired;

    assign accept      = (cur_state == S_IDLE) && start && !start_q;
    assign tick        = (cur_state == S_CAPTURE) && (samp_cnt == SDW'(SAMPLE_DIV - 1));
    assign last_wr     = mem_we_q && (wr_idx == AW'(NUM_BYTES - 1));
    assign last_rd     = (rd_idx == AW'(NUM_BYTES - 1));
    assign ack_expired = (ack_cnt == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE:     if (accept) nxt_state = S_CAPTURE;
                S_CAPTURE:  if (last_wr) nxt_state = S_XMIT;
                S_XMIT:     nxt_state = S_TX_ACK;
                S_TX_ACK: begin
                    if (bus.tx_busy)      nxt_state = S_TX_DRAIN;
                    else if (ack_expired) nxt_state = S_IDLE;
                end
                S_TX_DRAIN: if (!bus.tx_busy) nxt_state = last_rd ? S_DONE : S_XMIT;
                S_DONE:     nxt_state = S_IDLE;
                default:    nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= 1'b0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            ack_cnt     <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_wr_en_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            start_q    <= start;
            mem_we_q   <= 1'b0;
            tx_wr_en_q <= 1'b0;
            if (accept && !abort) begin
                samp_cnt <= '0;
                bit_cnt  <= '0;
                wr_idx   <= '0;
                rd_idx   <= '0;
                error_q  <= 1'b0;
            end
            // Sampling free-runs through the write cycle; bit_cnt wraps 7->0 on the byte boundary.
            if (cur_state == S_CAPTURE && !abort) begin
                samp_cnt <= tick ? '0 : samp_cnt + SDW'(1);
                if (tick) begin
                    shreg   <= {shreg[5:0], rand_bit};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {shreg, rand_bit};
                    end
                end
                if (mem_we_q && !last_wr) wr_idx <= wr_idx + AW'(1);
            end
            if (cur_state == S_XMIT && !abort) begin
                tx_data_q  <= bus.mem_rdata;
                tx_wr_en_q <= 1'b1;
                ack_cnt    <= '0;
            end
            if (cur_state == S_TX_ACK && !abort && !bus.tx_busy) begin
                if (ack_expired) error_q <= 1'b1;
                else             ack_cnt <= ack_cnt + TW'(1);
            end
            if (cur_state == S_TX_DRAIN && !abort && !bus.tx_busy && !last_rd)
                rd_idx <= rd_idx + AW'(1);
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = wr_idx;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_raddr = rd_idx;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_wr_en  = tx_wr_en_q;

    assign osc_en = (cur_state == S_CAPTURE);
    assign busy   = (cur_state != S_IDLE);
    assign done   = (cur_state == S_DONE);
    assign error  = error_q;
    assign state  = cur_state;
endmodule

// File: tb/tb_trng_burst_sequencer.sv
// Randomised bench for trng_burst_sequencer: RAM and UART models plus a sample-schedule reference.
// Latency: n/a; backpressure: UART model raises busy 2 cycles after a send and holds it 10 cycles.
module tb_trng_burst_sequencer;
    localparam int NB = 4;
    localparam int SD = 4;
    localparam int AT = 16;
    localparam int AW = 2;
    localparam int NR = 4096;

    logic       clk = 1'b0;
    logic       reset, start, abort, rand_bit;
    logic       osc_en, busy, done, error;
    logic [2:0] state;

    trng_burst_sequencer_if #(.AW(AW)) bus ();

    trng_burst_sequencer #(
        .NUM_BYTES  (NB),
        .SAMPLE_DIV (SD),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .rand_bit(rand_bit),
        .osc_en  (osc_en),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .state   (state),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [NB];
    assign bus.mem_rdata = ram[bus.mem_raddr];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int base = 1 << 30;
    int wa[$], wd[$], wrel[$], td[$];
    int done_cnt = 0, tx_rel = 0, err_rel = 0;
    bit err_seen = 1'b0;
    bit uart_en = 1'b1;
    bit rbits [NR];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    // Sample k (1-based) of a burst is taken at relative edge k*SD; bytes pack 8 samples MSB-first.
    function automatic logic [31:0] exp_byte(input int j);
        int v = 0;
        for (int i = 0; i < 8; i++) v = v * 2 + int'(rbits[(8 * j + i + 1) * SD]);
        return v;
    endfunction

    // Monitor, RAM write port and UART model, all acting 1 ns after each rising edge.
    initial begin
        int rel;
        int ucnt;
        ucnt = -1;
        rand_bit = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rel = cyc - base;
            if (rel + 1 >= 0 && rel + 1 < NR) rand_bit = rbits[rel + 1];
            else rand_bit = 1'($urandom_range(0, 1));
            if (bus.mem_we) begin
                ram[bus.mem_waddr] = bus.mem_wdata;
                wa.push_back(int'(bus.mem_waddr));
                wd.push_back(int'(bus.mem_wdata));
                wrel.push_back(rel);
            end
            if (bus.tx_wr_en) begin
                chk("txwr_while_busy", bus.tx_busy, 0);
                td.push_back(int'(bus.tx_data));
                tx_rel = rel;
            end
            if (done) done_cnt++;
            if (error && !err_seen) begin
                err_seen = 1'b1;
                err_rel  = rel;
            end
            if (bus.tx_wr_en) ucnt = 0;
            else if (ucnt >= 0 && ucnt < 12) ucnt++;
            else ucnt = -1;
            bus.tx_busy = uart_en && ucnt >= 2 && ucnt < 12;
        end
    end

    task automatic launch(input bit use_pattern, input string tag);
        logic [7:0] pat_v;
        pat_v = 8'hB2;
        for (int m = 0; m < NR; m++)
            rbits[m] = use_pattern ? pat_v[7 - (((m > 0 ? m - 1 : 0) / SD) % 8)]
                                   : 1'($urandom_range(0, 1));
        wa.delete(); wd.delete(); wrel.delete(); td.delete();
        err_seen = 1'b0;
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
        base = cyc + 1;
        @(posedge clk);
        #2;
        chk({tag, "_enter_state"}, state, 1);
        chk({tag, "_enter_osc"}, osc_en, 1);
        chk({tag, "_enter_busy"}, busy, 1);
        chk({tag, "_enter_err"}, error, 0);
    endtask

    task automatic wait_done(input int prev, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (done_cnt == prev && n < 3000);
        chk({tag, "_done"}, done_cnt, prev + 1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (state !== s && n < 3000);
        chk({tag, "_reach_state"}, state, s);
    endtask

    task automatic check_burst(input string tag);
        chk({tag, "_nwr"}, wa.size(), NB);
        for (int j = 0; j < NB && j < wa.size(); j++) begin
            chk($sformatf("%s_waddr%0d", tag, j), wa[j], j);
            chk($sformatf("%s_wdata%0d", tag, j), wd[j], exp_byte(j));
            chk($sformatf("%s_wtime%0d", tag, j), wrel[j], 8 * (j + 1) * SD);
            chk($sformatf("%s_ram%0d", tag, j), ram[j], exp_byte(j));
        end
        chk({tag, "_ntx"}, td.size(), NB);
        for (int j = 0; j < NB && j < td.size(); j++)
            chk($sformatf("%s_txdata%0d", tag, j), td[j], exp_byte(j));
    endtask

    initial begin
        int d0, ntx;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", state, 0);
        chk("rst_osc", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_txwr", bus.tx_wr_en, 0);
        chk("rst_raddr", bus.mem_raddr, 0);
        @(negedge clk) reset = 1'b0;

        // Fixed pattern gives 0xB2 in every byte.
        d0 = done_cnt;
        launch(1'b1, "pat");
        wait_done(d0, "pat");
        @(posedge clk); #2;
        chk("pat_idle_state", state, 0);
        chk("pat_idle_busy", busy, 0);
        chk("pat_done_pulse", done, 0);
        check_burst("pat");
        chk("pat_byte_b2", exp_byte(2), 8'hB2);

        // start held high, re-toggled mid-transmit: single burst only.
        d0 = done_cnt;
        launch(1'b0, "hold");
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (td.size() < 1 && n < 3000);
        end
        start = 1'b0;
        @(negedge clk) start = 1'b1;
        wait_done(d0, "hold");
        repeat (200) @(negedge clk);
        chk("hold_one_burst", done_cnt, d0 + 1);
        chk("hold_idle", state, 0);
        check_burst("hold");

        d0 = done_cnt;
        launch(1'b0, "fresh");
        wait_done(d0, "fresh");
        check_burst("fresh");

        // UART never acknowledges.
        uart_en = 1'b0;
        d0 = done_cnt;
        launch(1'b0, "tmo");
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!err_seen && n < 3000);
        end
        chk("tmo_seen", err_seen, 1);
        chk("tmo_delay", err_rel - tx_rel, AT);
        chk("tmo_state", state, 0);
        chk("tmo_ntx", td.size(), 1);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", error, 1);
        chk("tmo_no_done", done_cnt, d0);
        uart_en = 1'b1;
        d0 = done_cnt;
        launch(1'b0, "post_err");
        wait_done(d0, "post_err");
        check_burst("post_err");

        // abort during CAPTURE after the second write.
        d0 = done_cnt;
        launch(1'b0, "abc");
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (wa.size() < 2 && n < 3000);
        end
        chk("abc_two_writes", wa.size(), 2);
        abort = 1'b1;
        @(posedge clk); #2;
        chk("abc_state", state, 0);
        chk("abc_osc", osc_en, 0);
        chk("abc_done", done, 0);
        @(negedge clk) abort = 1'b0;
        repeat (300) @(negedge clk);
        chk("abc_no_more_we", wa.size(), 2);
        chk("abc_no_tx", td.size(), 0);
        chk("abc_no_done", done_cnt, d0);

        // abort during TX_DRAIN.
        d0 = done_cnt;
        launch(1'b0, "abd");
        wait_state(3'd4, "abd");
        abort = 1'b1;
        ntx = td.size();
        @(posedge clk); #2;
        chk("abd_state", state, 0);
        chk("abd_osc", osc_en, 0);
        chk("abd_txwr", bus.tx_wr_en, 0);
        @(negedge clk) abort = 1'b0;
        repeat (100) @(negedge clk);
        chk("abd_no_more_tx", td.size(), ntx);
        chk("abd_no_done", done_cnt, d0);

        // reset during TX_ACK.
        d0 = done_cnt;
        launch(1'b0, "rsa");
        wait_state(3'd3, "rsa");
        reset = 1'b1;
        start = 1'b0;
        ntx = td.size();
        @(posedge clk); #2;
        chk("rsa_state", state, 0);
        chk("rsa_busy", busy, 0);
        chk("rsa_osc", osc_en, 0);
        chk("rsa_err", error, 0);
        chk("rsa_txwr", bus.tx_wr_en, 0);
        chk("rsa_txdata", bus.tx_data, 0);
        chk("rsa_we", bus.mem_we, 0);
        chk("rsa_wdata", bus.mem_wdata, 0);
        chk("rsa_raddr", bus.mem_raddr, 0);
        chk("rsa_waddr", bus.mem_waddr, 0);
        @(negedge clk) reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("rsa_no_more_tx", td.size(), ntx);
        chk("rsa_no_done", done_cnt, d0);
        chk("rsa_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
